// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomberman top level.
// Button indices, default timing, repeat FSM states.
package bomberman_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  localparam int DEBOUNCE_CYC_DEF  = 10000;
  localparam int REPEAT_DELAY_DEF  = 150000;
  localparam int REPEAT_PERIOD_DEF = 50000;

  localparam int BTN_S = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  // Bits needed to count 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: synchroniser, debounce counter and
// hold-to-repeat FSM with registered pulse outputs.
module btn_channel
  import bomberman_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_raw,
  input  logic i_hold,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_rep
);

  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ?
    REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_w(RMAX);

  localparam logic [DW-1:0] D_TERM =
    DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] RD_TERM =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_TERM =
    RW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_dcnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_rep;
  logic [RW-1:0]          r_rcnt;
  rep_state_t             r_state;

  logic                   w_s;
  logic                   w_diff;
  logic                   w_dterm;
  logic                   w_rise;
  logic                   w_fall;
  rep_state_t             w_state_nxt;
  logic [RW-1:0]          w_rcnt_nxt;
  logic                   w_rep_nxt;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_diff  = w_s ^ r_level;
  assign w_dterm = w_diff && (r_dcnt == D_TERM);
  assign w_rise  = w_dterm && !r_level;
  assign w_fall  = w_dterm && r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_dcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
      if (!w_diff || w_dterm)
        r_dcnt <= '0;
      else if (r_dcnt != D_TERM)
        r_dcnt <= r_dcnt + 1'b1;
      if (w_dterm)
        r_level <= ~r_level;
      r_press   <= w_rise && !i_hold;
      r_release <= w_fall && !i_hold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_rep   <= w_rep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rep_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = DELAY;
          w_rcnt_nxt  = '0;
          w_rep_nxt   = 1'b1;
        end
      end
      DELAY: begin
        if (r_rcnt == RD_TERM) begin
          w_state_nxt = REPEAT;
          w_rcnt_nxt  = '0;
          w_rep_nxt   = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end
      REPEAT: begin
        if (r_rcnt == RP_TERM) begin
          w_rcnt_nxt = '0;
          w_rep_nxt  = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
    // Release beats a coincident repeat tick.
    if (w_fall) begin
      w_state_nxt = IDLE;
      w_rcnt_nxt  = '0;
      w_rep_nxt   = 1'b0;
    end
    if (i_hold || !REPEAT_EN) begin
      w_state_nxt = IDLE;
      w_rcnt_nxt  = '0;
      w_rep_nxt   = !REPEAT_EN && w_rise && !i_hold;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_rep     = r_rep;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one independent
// btn_channel per button, repeat enabled per channel.
module btn_conditioner
  import bomberman_pkg::*;
#(
  parameter int N_CH          = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter logic [N_CH-1:0] REPEAT_EN =
    N_CH'(5'b11110)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] i_btn_raw,
  input  logic            i_hold,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_rep
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN    (REPEAT_EN[g])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_btn_raw(i_btn_raw[g]),
      .i_hold   (i_hold),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_rep    (o_rep[g])
    );
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised multi-channel push-button conditioner for the bomberman top level; replaces per-button ad-hoc debouncing. Each channel is a separate instance of one sub-module. Each channel synchronises its raw button input, debounces it, and produces the following outputs:
- a debounced level;
- single-cycle press and release pulses;
- an optional hold-to-repeat pulse train.

The outputs feed player movement (btnU/D/L/R) and bomb drop (btnS).

## Interface
Parameters:
- N_CH, 5: number of button channels.
- SYNC_STAGES, 2: synchroniser flops per channel, ≥2.
- DEBOUNCE_CYC, 10000: consecutive stable cycles required to accept a level change, ≥2.
- REPEAT_DELAY, 150000: cycles from press to first auto-repeat pulse, ≥2.
- REPEAT_PERIOD, 50000: cycles between subsequent repeat pulses, ≥1.
- REPEAT_EN, 5'b11110: per-channel mask; bit set = channel auto-repeats.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  N_CH  raw, asynchronous button inputs, active-high.
- hold  in  1  freeze: suppresses all pulses and clears repeat timers.
- level  out  N_CH  debounced button state.
- press  out  N_CH  one-cycle pulse on accepted 0→1.
- release  out  N_CH  one-cycle pulse on accepted 1→0.
- rep  out  N_CH  press plus auto-repeat pulses (one cycle each).

## Operation
- Synchroniser: btn_raw[i] passes through SYNC_STAGES flops; the last stage is s[i].
- Debounce:
  - Counter dcnt resets to 0 whenever s equals level.
  - Otherwise dcnt increments each cycle.
  - When dcnt == DEBOUNCE_CYC-1 and s still differs, level toggles on the next edge and dcnt clears.
  - Any glitch back to level before that restarts the count.
- press/release are registered, asserted in the same cycle level changes, and last 1 cycle.
- Per-channel repeat FSM, states IDLE, DELAY, REPEAT:
  - IDLE→DELAY on accepted press; rep pulses the same cycle as press; rcnt←0.
  - DELAY: rcnt increments; at rcnt == REPEAT_DELAY-1, rep pulses, rcnt←0, →REPEAT.
  - REPEAT: at rcnt == REPEAT_PERIOD-1, rep pulses and rcnt←0.
  - Any state→IDLE on accepted release; no rep is produced in the release cycle.
  - REPEAT_EN[i]==0: FSM pinned to IDLE; rep[i] == press[i].
- hold=1:
  - press, release and rep are forced to 0.
  - FSM→IDLE and rcnt←0.
  - level keeps tracking.
  - Deasserting hold while a button is held gives no press; the next rep needs release followed by a new press.
- Counter widths are $clog2 of their max value, with no wrap. A counter saturates at its terminal value and never exceeds it.
- Channels are fully independent: simultaneous presses on all N_CH channels are all reported in the same cycle.

## Timing
- Reset (rst_n=0, asynchronous): all synchroniser flops 0, level 0, press/release/rep 0, dcnt/rcnt 0, FSM IDLE. Outputs are valid at the first clk edge after deassertion.
- Latency, clean raw edge → press/level: SYNC_STAGES + DEBOUNCE_CYC cycles. The same latency applies to release.
- Press → first auto-rep: REPEAT_DELAY cycles; later reps every REPEAT_PERIOD cycles.
- Raw pulses shorter than DEBOUNCE_CYC cycles after synchronisation produce no output.
- Reset asserted mid-debounce or mid-repeat aborts immediately. A button held through reset yields a fresh press after SYNC_STAGES + DEBOUNCE_CYC cycles.
- Release and REPEAT terminal count in the same cycle: release wins, rep=0.

## Structure
- Shared package bomberman_pkg holds:
  - enum rep_state_t {IDLE, DELAY, REPEAT};
  - default timing constants: DEBOUNCE_CYC_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF;
  - button index constants BTN_S, BTN_U, BTN_D, BTN_L, BTN_R.
- Sub-module btn_channel holds synchroniser, debounce counter and repeat FSM for one button. btn_conditioner is a generate loop over N_CH instances plus the per-channel REPEAT_EN selection.

## Test plan
Bench parameters: N_CH=5, SYNC_STAGES=2, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=5'b11110.
- Reset: hold rst_n=0 with btn_raw=5'h1F → all outputs 0. Release reset → press=5'h1F exactly 6 cycles later, one cycle wide.
- Glitch: 3-cycle high pulse on btn_raw[1] → level, press and rep stay 0 throughout.
- Auto-repeat: hold btn_raw[1] for 40 cycles → rep[1] at press cycle, then +10, +13, +16, …. release[1] arrives 6 cycles after the raw fall, with no rep that cycle.
- Non-repeat channel: hold btn_raw[0] (bomb) for 40 cycles → exactly one rep[0]/press[0] pulse, coincident.
- Hold: assert hold while btn_raw[2] is held in REPEAT → rep[2] stops at once. Deassert hold → no pulses until release and a fresh press.
- Simultaneous: raise btn_raw[4:1] together, then async reset at cycle 15 → four coincident press pulses. After reset all outputs return to 0 and re-press after 6 cycles.
